// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-Lite to APB bridge: FSM states, AHB transfer
// types, the single legal transfer size and response codes.
package ahb_apb_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WDATA  = 3'd1;
    localparam state_t ST_SETUP  = 3'd2;
    localparam state_t ST_ACCESS = 3'd3;
    localparam state_t ST_ERR1   = 3'd4;
    localparam state_t ST_ERR2   = 3'd5;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_apb_bridge.sv
// Single-slave AHB-Lite to APB bridge: one AHB word transfer becomes one APB
// SETUP/ACCESS pair, with a bounded PREADY timeout that ends in an ERROR response.
module ahb_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int HADDR_WIDTH    = 32,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT        = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL,
    input  logic [HADDR_WIDTH-1:0]    HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [31:0]               HWDATA,
    input  logic                      HREADY,
    output logic                      HREADYOUT,
    output logic                      HRESP,
    output logic [31:0]               HRDATA,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t                      state_r;
    state_t                      state_nx_s;
    state_t                      launch_st_s;
    logic [7:0]                  cnt_r;
    logic [31:0]                 hrdata_r;
    logic [APB_ADDR_WIDTH-1:0]   paddr_r;
    logic [31:0]                 pwdata_r;
    logic                        pwrite_r;
    logic                        psel_r;
    logic                        penable_r;
    logic                        hresp_r;
    logic                        accept_s;
    logic                        size_ok_s;
    logic                        done_s;
    logic                        read_done_s;
    logic                        take_s;
    logic                        unused_s;

    assign accept_s    = HSEL & HREADY & htrans_active(HTRANS);
    assign size_ok_s   = (HSIZE == HSIZE_WORD);
    assign done_s      = (state_r == ST_ACCESS) & PREADY & ~PSLVERR;
    assign read_done_s = done_s & ~pwrite_r;
    assign launch_st_s = !size_ok_s ? ST_ERR1 : (HWRITE ? ST_WDATA : ST_SETUP);
    // New address phases are only sampled when the bridge itself is ready.
    assign take_s      = accept_s & size_ok_s &
                         ((state_r == ST_IDLE) | (state_r == ST_ERR2) | done_s);
    assign unused_s    = ^{HADDR[HADDR_WIDTH-1:APB_ADDR_WIDTH], 1'b0};

    // Next-state decode for the transfer FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:   state_nx_s = accept_s ? launch_st_s : ST_IDLE;
            ST_WDATA:  state_nx_s = ST_SETUP;
            ST_SETUP:  state_nx_s = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_nx_s = ST_ERR1;
                    end else begin
                        state_nx_s = accept_s ? launch_st_s : ST_IDLE;
                    end
                end else if ((cnt_r + 8'd1) == TIMEOUT_C) begin
                    state_nx_s = ST_ERR1;
                end else begin
                    state_nx_s = ST_ACCESS;
                end
            end
            ST_ERR1:   state_nx_s = ST_ERR2;
            ST_ERR2:   state_nx_s = accept_s ? launch_st_s : ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // Wait states come straight from PREADY so each stalled ACCESS adds one.
    always_comb begin
        HREADYOUT = 1'b1;
        case (state_r)
            ST_WDATA:  HREADYOUT = 1'b0;
            ST_SETUP:  HREADYOUT = 1'b0;
            ST_ACCESS: HREADYOUT = done_s;
            ST_ERR1:   HREADYOUT = 1'b0;
            default:   HREADYOUT = 1'b1;
        endcase
    end

    // FSM state and PREADY-low timeout counter.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nx_s;
            if (state_nx_s == ST_SETUP) begin
                cnt_r <= 8'd0;
            end else if ((state_r == ST_ACCESS) && !PREADY) begin
                cnt_r <= cnt_r + 8'd1;
            end
        end
    end

    // APB request fields, captured once and held through SETUP and ACCESS.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            paddr_r  <= '0;
            pwrite_r <= 1'b0;
            pwdata_r <= 32'd0;
        end else begin
            if (take_s) begin
                paddr_r  <= HADDR[APB_ADDR_WIDTH-1:0];
                pwrite_r <= HWRITE;
            end
            if (state_r == ST_WDATA) begin
                pwdata_r <= HWDATA;
            end
        end
    end

    // Bus control outputs registered from the next state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            hresp_r   <= HRESP_OKAY;
            hrdata_r  <= 32'd0;
        end else begin
            psel_r    <= (state_nx_s == ST_SETUP) || (state_nx_s == ST_ACCESS);
            penable_r <= (state_nx_s == ST_ACCESS);
            hresp_r   <= ((state_nx_s == ST_ERR1) || (state_nx_s == ST_ERR2)) ?
                         HRESP_ERROR : HRESP_OKAY;
            if (read_done_s) begin
                hrdata_r <= PRDATA;
            end
        end
    end

    // Read data is forwarded in the completion cycle, then held from the register.
    assign HRDATA  = read_done_s ? PRDATA : hrdata_r;
    assign HRESP   = hresp_r;
    assign PADDR   = paddr_r;
    assign PWDATA  = pwdata_r;
    assign PWRITE  = pwrite_r;
    assign PSEL    = psel_r;
    assign PENABLE = penable_r;

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

Single-slave AHB-Lite to APB bridge placed directly upstream of the APB timer peripheral. It converts one AHB-Lite data-phase transfer into one APB SETUP/ACCESS pair and returns read data, wait states and error responses to the AHB master. Word accesses only. It also applies a bounded PREADY timeout so a hung peripheral cannot stall the bus.

## Interface
Parameters:
- HADDR_WIDTH, 32, AHB address width
- APB_ADDR_WIDTH, 12, APB address width; PADDR = captured HADDR[APB_ADDR_WIDTH-1:0]
- TIMEOUT, 255, max ACCESS cycles with PREADY low before error; 8-bit counter

Ports:
- HCLK  in  1  clock; all logic on rising edge
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  bridge selected
- HADDR  in  HADDR_WIDTH  address phase address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  address-phase direction
- HSIZE  in  3  transfer size; only 3'b010 legal
- HWDATA  in  32  write data, valid in data phase
- HREADY  in  1  bus-wide ready
- HREADYOUT  out  1  bridge ready
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  32  read data
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

## Operation
- Transfer accepted when HSEL & HREADY & HTRANS[1] on a rising edge; HADDR, HWRITE and size legality registered.
- BUSY and IDLE HTRANS are ignored and return OKAY with zero wait states.
- FSM states: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- IDLE:
  - legal write -> WDATA
  - legal read -> SETUP
  - illegal HSIZE -> ERR1; no APB cycle
- WDATA: HWDATA registered into PWDATA; -> SETUP.
- SETUP: PSEL=1, PENABLE=0; -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY & !PSLVERR: transfer done; HREADYOUT=1, HRDATA=PRDATA (reads). Accept a new transfer this same cycle (back-to-back), else -> IDLE.
  - PREADY & PSLVERR -> ERR1.
  - !PREADY: timeout counter increments; when it reaches TIMEOUT -> ERR1 and drop PSEL/PENABLE.
- ERR1: HREADYOUT=0, HRESP=1; -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1. New address phase accepted as in IDLE. A master cancelling drives HTRANS=IDLE, so nothing is captured.
- PADDR, PWRITE, PWDATA are held stable from SETUP through the end of ACCESS.
- HRDATA is registered from PRDATA on read completion and held until the next read completes.
- Timeout counter clears on entry to SETUP.

## Timing
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0
  - state=IDLE, counter=0
- Cycle numbering: address phase = cycle 0.
- Write with PREADY=1: WDATA c1, SETUP c2, ACCESS c3; HREADYOUT low c1-c2, high c3.
- Read with PREADY=1: SETUP c1, ACCESS c2; HREADYOUT low c1, high c2; HRDATA valid c2.
- Each PREADY-low ACCESS cycle adds one wait state.
- Error response is always two cycles: HRESP high in ERR1 and ERR2, HREADYOUT low then high.
- A reset mid-transfer immediately drops PSEL/PENABLE and forces IDLE. No APB or AHB completion is generated.

## Structure
- Package ahb_apb_pkg holds:
  - state enum
  - HTRANS encodings
  - HSIZE_WORD = 3'b010
  - HRESP_OKAY / HRESP_ERROR constants
- Single module; no sub-module. The timeout counter is inline.

## Test plan
- Write 0x0000_0020 to HADDR 0x004, PREADY tied 1 -> PADDR=0x004, PWDATA=0x20, PWRITE=1. PSEL rises c2, PENABLE c3; HREADYOUT low c1-c2; HRESP=0.
- Read HADDR 0x008, PRDATA=0xDEAD_BEEF -> HRDATA=0xDEAD_BEEF with HREADYOUT=1 in c2.
- Back-to-back NONSEQ read then write, both issued in the completion cycle -> two APB transfers with no IDLE cycle between, correct data order.
- PSLVERR=1 on a read -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1, HRDATA unchanged.
- PREADY held 0, TIMEOUT=4 -> PSEL drops after 4 ACCESS cycles, then two-cycle ERROR response. HSIZE=3'b000 -> two-cycle ERROR with PSEL never asserted.
- HRESETn pulled low during ACCESS -> all outputs at reset values asynchronously; next transfer after release completes normally.
